// File: rtl/sys_timer_array.sv
// Array of independent down-counting timer channels sharing one interrupt line,
// with an IDLE/REQ/SERVICE handshake toward the interrupt controller.
module sys_timer_array #(
  parameter int unsigned        NUM_CH         = 4,
  parameter int unsigned        CNT_W          = 24,
  parameter logic [CNT_W-1:0]   DEFAULT_RELOAD = CNT_W'(499999),
  localparam int unsigned       ID_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [ID_W-1:0]   wr_ch_i,
  input  logic              wr_sel_i,
  input  logic [CNT_W-1:0]  wr_data_i,
  output logic              intc_irq_o,
  input  logic              intc_iack_i,
  input  logic              intc_iend_i,
  output logic [ID_W-1:0]   intc_vec_o,
  output logic [NUM_CH-1:0] overrun_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    vec_q, vec_d;
  logic [CNT_W-1:0]   reload_q [NUM_CH];
  logic [CNT_W-1:0]   reload_d [NUM_CH];
  logic [CNT_W-1:0]   count_q  [NUM_CH];
  logic [CNT_W-1:0]   count_d  [NUM_CH];
  logic [NUM_CH-1:0]  en_q, en_d, periodic_q, periodic_d;
  logic [NUM_CH-1:0]  pending_q, pending_d, overrun_q, overrun_d;
  logic [NUM_CH-1:0]  wr_hit, ack_clr;
  logic [ID_W-1:0]    ack_idx;

  // Lowest-index pending channel wins the vector.
  always_comb begin
    ack_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) ack_idx = ID_W'(i);
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    ack_clr = '0;
    unique case (state_q)
      S_IDLE:    if (|pending_q) state_d = S_REQ;
      S_REQ: begin
        if (intc_iack_i) begin
          state_d = S_SERVICE;
          vec_d   = ack_idx;
          ack_clr = NUM_CH'(1) << ack_idx;
        end
      end
      S_SERVICE: if (intc_iend_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = wr_en_i && (int'(wr_ch_i) == i);
    end
  end

  // Expiry is evaluated first; a register write to the same channel then overrides.
  always_comb begin
    reload_d   = reload_q;
    count_d    = count_q;
    en_d       = en_q;
    periodic_d = periodic_q;
    pending_d  = pending_q & ~ack_clr;
    overrun_d  = overrun_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en_q[i]) begin
        if (count_q[i] == '0) begin
          count_d[i]   = reload_q[i];
          pending_d[i] = 1'b1;
          if (pending_q[i] && !ack_clr[i]) overrun_d[i] = 1'b1;
          if (!periodic_q[i]) en_d[i] = 1'b0;
        end else begin
          count_d[i] = count_q[i] - 1'b1;
        end
      end
      if (wr_hit[i]) begin
        if (!wr_sel_i) begin
          reload_d[i] = wr_data_i;
        end else begin
          en_d[i]       = wr_data_i[0];
          periodic_d[i] = wr_data_i[1];
          overrun_d[i]  = 1'b0;
          if (!wr_data_i[0])  count_d[i] = count_q[i];
          else if (!en_q[i])  count_d[i] = reload_q[i];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      vec_q      <= '0;
      pending_q  <= '0;
      overrun_q  <= '0;
      en_q       <= NUM_CH'(1);
      periodic_q <= NUM_CH'(1);
      // NOTE: the per-channel arrays are real control registers, not RAM, so they are reset.
      for (int i = 0; i < NUM_CH; i++) begin
        reload_q[i] <= (i == 0) ? DEFAULT_RELOAD : '0;
        count_q[i]  <= (i == 0) ? DEFAULT_RELOAD : '0;
      end
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
    end
  end

  assign intc_irq_o = (state_q == S_REQ);
  assign intc_vec_o = vec_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_sys_timer_array.sv
// Bench for sys_timer_array: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the timer channels and handshake.
module tb_sys_timer_array;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 24;
  localparam int ID_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [ID_W-1:0]   wr_ch = '0;
  logic              wr_sel = 1'b0;
  logic [CNT_W-1:0]  wr_data = '0;
  logic              iack = 1'b0;
  logic              iend = 1'b0;
  logic              irq;
  logic [ID_W-1:0]   vec;
  logic [NUM_CH-1:0] ovr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sys_timer_array #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_RELOAD(24'd9)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en_i(wr_en), .wr_ch_i(wr_ch), .wr_sel_i(wr_sel), .wr_data_i(wr_data),
    .intc_irq_o(irq), .intc_iack_i(iack), .intc_iend_i(iend),
    .intc_vec_o(vec), .overrun_o(ovr)
  );

  // Behavioural reference: plain integers per channel, handshake as 0=idle 1=req 2=service.
  int              m_reload [NUM_CH];
  int              m_cnt    [NUM_CH];
  bit [NUM_CH-1:0] m_en, m_per, m_pend, m_ovr;
  int              m_st, m_vec;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_reload[i] = (i == 0) ? 9 : 0;
      m_cnt[i]    = (i == 0) ? 9 : 0;
    end
    m_en = 4'b0001; m_per = 4'b0001; m_pend = '0; m_ovr = '0;
    m_st = 0; m_vec = 0;
  endtask

  task automatic model_step();
    bit [NUM_CH-1:0] fire, old_en;
    int old_cnt [NUM_CH];
    int ack = -1;
    old_en = m_en;
    for (int i = 0; i < NUM_CH; i++) begin
      fire[i]    = m_en[i] && (m_cnt[i] == 0);
      old_cnt[i] = m_cnt[i];
    end
    if (m_st == 1 && iack) begin
      for (int i = 0; i < NUM_CH; i++) if (m_pend[i]) begin ack = i; break; end
    end
    case (m_st)
      0: if (m_pend != 0) m_st = 1;
      1: if (iack) begin m_vec = ack; m_st = 2; end
      default: if (iend) m_st = 0;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (fire[i]) begin
        if (m_pend[i] && ack != i) m_ovr[i] = 1'b1;
        m_pend[i] = 1'b1;
        m_cnt[i]  = m_reload[i];
        if (!m_per[i]) m_en[i] = 1'b0;
      end else begin
        if (ack == i) m_pend[i] = 1'b0;
        if (m_en[i]) m_cnt[i] = m_cnt[i] - 1;
      end
    end
    if (wr_en && int'(wr_ch) < NUM_CH) begin
      if (!wr_sel) m_reload[wr_ch] = int'(wr_data);
      else begin
        m_ovr[wr_ch] = 1'b0;
        if (!wr_data[0])        m_cnt[wr_ch] = old_cnt[wr_ch];
        else if (!old_en[wr_ch]) m_cnt[wr_ch] = m_reload[wr_ch];
        m_en[wr_ch]  = wr_data[0];
        m_per[wr_ch] = wr_data[1];
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Stimulus helpers: all start and end just after a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; wr_en = 1'b0; iack = 1'b0; iend = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wr(input int ch, input bit sel, input int data);
    wr_en = 1'b1; wr_ch = ID_W'(ch); wr_sel = sel; wr_data = CNT_W'(data);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_iack();
    iack = 1'b1; @(negedge clk); iack = 1'b0;
  endtask

  task automatic pulse_iend();
    iend = 1'b1; @(negedge clk); iend = 1'b0;
  endtask

  task automatic wait_irq(input int max, output int n);
    n = 0;
    while (irq !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_cmp++; if (vec !== 2'd0) begin n_bad++; $display("FAIL reset_vec: got %0d want 0", vec); end
    n_cmp++; if (ovr !== 4'b0) begin n_bad++; $display("FAIL reset_ovr: got %b want 0000", ovr); end
    n_cmp++; if (dut.count_q[0] !== 24'd9) begin n_bad++; $display("FAIL reset_cnt0: got %0d want 9", dut.count_q[0]); end
    n_cmp++; if (dut.en_q !== 4'b0001) begin n_bad++; $display("FAIL reset_en: got %b want 0001", dut.en_q); end
  endtask

  task automatic test_tick();
    int n;
    do_reset();
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      n_cmp++;
      if (irq !== (k == 11)) begin n_bad++; $display("FAIL tick_rise k=%0d: got %b want %b", k, irq, (k == 11)); end
    end
    pulse_iack();
    n_cmp++; if (irq !== 1'b0 || vec !== 2'd0) begin n_bad++; $display("FAIL tick_ack: irq %b vec %0d want 0/0", irq, vec); end
    pulse_iend();
    wait_irq(20, n);
    n_cmp++; if (irq !== 1'b1 || n + 2 != 10) begin n_bad++; $display("FAIL tick_period: irq %b gap %0d want 1 and 10", irq, n + 2); end
  endtask

  task automatic test_oneshot();
    int n;
    int seen = 0;
    do_reset();
    wr(0, 1, 0);
    wr(2, 0, 3);
    wr(2, 1, 1);
    wait_irq(20, n);
    n_cmp++; if (irq !== 1'b1 || n != 5) begin n_bad++; $display("FAIL oneshot_rise: irq %b after %0d want 1 after 5", irq, n); end
    pulse_iack();
    n_cmp++; if (vec !== 2'd2) begin n_bad++; $display("FAIL oneshot_vec: got %0d want 2", vec); end
    pulse_iend();
    repeat (30) begin @(negedge clk); if (irq === 1'b1) seen++; end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL oneshot_repeat: got %0d irq cycles want 0", seen); end
    n_cmp++; if (dut.en_q[2] !== 1'b0) begin n_bad++; $display("FAIL oneshot_en: got %b want 0", dut.en_q[2]); end
  endtask

  task automatic test_same_cycle();
    int n;
    do_reset();
    wr(0, 1, 0);
    wr(1, 0, 5);
    wr(3, 0, 4);
    wr(1, 1, 1);
    wr(3, 1, 1);
    wait_irq(20, n);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL dual_irq1: got %b want 1", irq); end
    pulse_iack();
    n_cmp++; if (vec !== 2'd1) begin n_bad++; $display("FAIL dual_vec1: got %0d want 1", vec); end
    n_cmp++; if (dut.pending_q !== 4'b1000) begin n_bad++; $display("FAIL dual_pend: got %b want 1000", dut.pending_q); end
    pulse_iend();
    wait_irq(20, n);
    n_cmp++; if (irq !== 1'b1 || n != 1) begin n_bad++; $display("FAIL dual_irq2: irq %b after %0d want 1 after 1", irq, n); end
    pulse_iack();
    n_cmp++; if (vec !== 2'd3) begin n_bad++; $display("FAIL dual_vec2: got %0d want 3", vec); end
    pulse_iend();
  endtask

  task automatic test_overrun();
    do_reset();
    repeat (19) @(negedge clk);
    n_cmp++; if (ovr !== 4'b0000 || irq !== 1'b1) begin n_bad++; $display("FAIL ovr_before: ovr %b irq %b want 0000/1", ovr, irq); end
    @(negedge clk);
    n_cmp++; if (ovr !== 4'b0001) begin n_bad++; $display("FAIL ovr_set: got %b want 0001", ovr); end
    wr(0, 1, 3);
    n_cmp++; if (ovr !== 4'b0000) begin n_bad++; $display("FAIL ovr_clear: got %b want 0000", ovr); end
  endtask

  task automatic test_reset_in_service();
    int n;
    do_reset();
    wr(0, 1, 0);
    wr(2, 0, 2);
    wr(2, 1, 3);
    wait_irq(20, n);
    pulse_iack();
    n_cmp++; if (vec !== 2'd2) begin n_bad++; $display("FAIL rsvc_vec: got %0d want 2", vec); end
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (irq !== 1'b0 || vec !== 2'd0) begin n_bad++; $display("FAIL rsvc_out: irq %b vec %0d want 0/0", irq, vec); end
    n_cmp++; if (dut.pending_q !== 4'b0 || dut.count_q[0] !== 24'd9) begin
      n_bad++; $display("FAIL rsvc_state: pend %b cnt0 %0d want 0000/9", dut.pending_q, dut.count_q[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      n_cmp++;
      if (irq !== (k == 11)) begin n_bad++; $display("FAIL rsvc_restart k=%0d: got %b want %b", k, irq, (k == 11)); end
    end
  endtask

  task automatic test_spurious();
    do_reset();
    pulse_iack();
    n_cmp++; if (irq !== 1'b0 || vec !== 2'd0) begin n_bad++; $display("FAIL spur_idle: irq %b vec %0d want 0/0", irq, vec); end
    repeat (9) @(negedge clk);
    pulse_iack();
    n_cmp++; if (irq !== 1'b1 || dut.pending_q[0] !== 1'b1) begin
      n_bad++; $display("FAIL spur_ack_idle: irq %b pend0 %b want 1/1", irq, dut.pending_q[0]);
    end
    pulse_iend();
    n_cmp++; if (irq !== 1'b1 || dut.pending_q[0] !== 1'b1) begin
      n_bad++; $display("FAIL spur_end_req: irq %b pend0 %b want 1/1", irq, dut.pending_q[0]);
    end
    pulse_iack();
    n_cmp++; if (irq !== 1'b0 || vec !== 2'd0 || dut.pending_q[0] !== 1'b0) begin
      n_bad++; $display("FAIL spur_real_ack: irq %b vec %0d pend0 %b want 0/0/0", irq, vec, dut.pending_q[0]);
    end
    pulse_iend();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      n_cmp++;
      if (irq !== (m_st == 1) || int'(vec) != m_vec || ovr !== m_ovr || dut.pending_q !== m_pend) begin
        n_bad++;
        $display("FAIL rand c=%0d: irq %b vec %0d ovr %b pend %b want %b %0d %b %b",
                 c, irq, vec, ovr, dut.pending_q, (m_st == 1), m_vec, m_ovr, m_pend);
      end
      wr_en  = ($urandom_range(0, 5) == 0);
      wr_ch  = ID_W'($urandom_range(0, NUM_CH - 1));
      wr_sel = 1'($urandom_range(0, 1));
      wr_data = wr_sel ? CNT_W'($urandom_range(0, 3)) : CNT_W'($urandom_range(0, 12));
      iack   = ($urandom_range(0, 2) == 0);
      iend   = ($urandom_range(0, 3) == 0);
    end
    wr_en = 1'b0; iack = 1'b0; iend = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tick();
    test_oneshot();
    test_same_cycle();
    test_overrun();
    test_reset_in_service();
    test_spurious();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sys_timer_array.md
SYS_TIMER_ARRAY -- requirements
Module: sys_timer_array

Interface
REQ-001 The block SHALL take parameter NUM_CH, default 4: number of independent timer channels, 1..16.
REQ-002 The block SHALL take parameter CNT_W, default 24: counter and reload width in bits.
REQ-003 The block SHALL take parameter DEFAULT_RELOAD, default 499999: channel-0 reload after reset, giving a 20 ms period at a 25 MHz clock.
REQ-004 The block SHALL derive localparam ID_W = max(1, clog2(NUM_CH)).
REQ-005 CLK  input  1  system clock; all state updates on its rising edge.
REQ-006 RESET  input  1  asynchronous, active-low reset.
REQ-007 WR_EN  input  1  register write strobe, one cycle per write.
REQ-008 WR_CH  input  ID_W  target channel of the write.
REQ-009 WR_SEL  input  1  write target: 0 = reload register, 1 = control register.
REQ-010 WR_DATA  input  CNT_W  write data; for control writes, bit0 = enable and bit1 = periodic (1) / one-shot (0).
REQ-011 INTC_IRQ  output  1  interrupt request to the interrupt controller.
REQ-012 INTC_IACK  input  1  interrupt acknowledge, one-cycle pulse.
REQ-013 INTC_IEND  input  1  end of interrupt service, one-cycle pulse.
REQ-014 INTC_VEC  output  ID_W  channel being serviced; valid from the cycle after IACK until the next IACK.
REQ-015 OVERRUN  output  NUM_CH  per-channel sticky flag: an expiry occurred while that channel's pending bit was already set.

Function
REQ-016 Each channel SHALL hold these registers: reload[CNT_W], count[CNT_W], en, periodic, pending, overrun.
REQ-017 An enabled channel SHALL decrement count by 1 every cycle; a disabled channel SHALL hold count.
REQ-018 An enabled channel with count == 0 SHALL expire that cycle: set pending and load count = reload; the period is therefore reload+1 cycles.
REQ-019 On expiry, a one-shot channel SHALL additionally clear en.
REQ-020 On expiry with pending already 1, the channel SHALL set overrun; pending stays 1 and no second request is queued.
REQ-021 A reload write SHALL update reload only; the running count is unaffected until the next expiry.
REQ-022 A control write SHALL update en and periodic, and SHALL clear that channel's overrun.
REQ-023 A control write that takes en from 0 to 1 SHALL also load count = reload.
REQ-024 A control write with en = 0 SHALL freeze count and leave pending untouched.
REQ-025 A write with WR_CH >= NUM_CH SHALL be ignored.
REQ-026 The handshake FSM SHALL have states IDLE, REQ and SERVICE.
REQ-027 In IDLE, if any pending bit is 1, the FSM SHALL go to REQ on the next edge; INTC_IRQ SHALL be registered and equal 1 exactly when the state is REQ.
REQ-028 In REQ, on INTC_IACK = 1, the FSM SHALL load INTC_VEC with the lowest-index pending channel, clear that pending bit, and go to SERVICE.
REQ-029 In SERVICE, on INTC_IEND = 1, the FSM SHALL go to IDLE; the next request therefore appears no earlier than 2 cycles after IEND.
REQ-030 IACK outside REQ and IEND outside SERVICE SHALL be ignored.
REQ-031 If the IACK clear and a new expiry hit the same channel in the same cycle, the set SHALL win: pending stays 1 and overrun is not set.
REQ-032 Pending bits SHALL keep accumulating in all FSM states; none is lost while another channel is in service.

Reset
REQ-033 While RESET = 0, the block SHALL asynchronously force: state = IDLE, INTC_IRQ = 0, INTC_VEC = 0, all pending = 0, OVERRUN = 0.
REQ-034 While RESET = 0, channel 0 SHALL be forced to reload = count = DEFAULT_RELOAD, en = 1, periodic = 1, so that it behaves as the legacy fixed-period system tick.
REQ-035 While RESET = 0, channels 1..NUM_CH-1 SHALL be forced to reload = count = 0, en = 0, periodic = 0.
REQ-036 Reset asserted mid-service SHALL abandon the service: no IEND is required afterwards.

Verification
REQ-037 Bench SHALL use NUM_CH = 4, DEFAULT_RELOAD = 9.
REQ-038 Release reset, no writes -> INTC_IRQ rises 11 cycles after release; IACK -> INTC_VEC = 0 and IRQ drops next cycle; IEND -> the next IRQ lands exactly 10 cycles after the previous one.
REQ-039 Write ch2 reload = 3, then control = 0b01 (one-shot) -> a single ch2 request with VEC = 2; no further ch2 request; ch2 en reads as cleared.
REQ-040 ch1 and ch3 expire in the same cycle -> first IACK gives VEC = 1, IEND, second IRQ, IACK gives VEC = 3.
REQ-041 Withhold IACK past two ch0 periods -> OVERRUN[0] = 1; control write to ch0 -> OVERRUN[0] = 0.
REQ-042 Assert RESET in SERVICE, then release -> IRQ = 0, VEC = 0, pending cleared, ch0 restarts with count = 9.
REQ-043 IACK pulsed in IDLE and IEND pulsed in REQ -> no state change, no pending bit cleared.
